// File: rtl/cmp_pkg.sv
// Shared types for the bit-serial comparator sequencer.
// Result vectors are ordered {AeB, AsB, AiB}.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RES_AEB = 2;
  localparam int RES_ASB = 1;
  localparam int RES_AIB = 0;

  function automatic logic [2:0] res_pack(
    input logic gt,
    input logic lt
  );
    logic [2:0] r;
    r          = '0;
    r[RES_AEB] = ~(gt | lt);
    r[RES_ASB] = gt;
    r[RES_AIB] = lt;
    return r;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Combinational 1-bit magnitude comparator cell.
// AsB: a > b, AiB: a < b, AeB: a == b.
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  output logic AeB,
  output logic AsB,
  output logic AiB
);

  assign AsB = a & ~b;
  assign AiB = ~a & b;
  assign AeB = ~(AsB | AiB);

endmodule

// File: rtl/bit_serial_comparator_ctrl.sv
// Sequencer driving one shared bit cell MSB first,
// latching a one-hot {AeB, AsB, AiB} result.
module bit_serial_comparator_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             AeB,
  output logic             AsB,
  output logic             AiB
);

  localparam int IW =
    (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP =
    IW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [IW-1:0]    r_idx;
  logic             r_have;
  logic             r_gt;
  logic             r_lt;
  logic [2:0]       r_res;

  logic w_a;
  logic w_b;
  logic w_ceq;
  logic w_cgt;
  logic w_clt;
  logic w_accept;
  logic w_first;
  logic w_last;
  logic w_finish;
  logic w_gt_fin;
  logic w_lt_fin;

  assign w_a = r_sa[r_idx];
  assign w_b = r_sb[r_idx];

  cmp_bit_cell u_cell (
    .a   (w_a),
    .b   (w_b),
    .AeB (w_ceq),
    .AsB (w_cgt),
    .AiB (w_clt)
  );

  assign w_accept = start && (r_state != RUN);
  assign w_first  = (w_cgt | w_clt) & ~r_have;
  assign w_last   = (r_idx == '0);
  assign w_finish = w_last ||
    ((EARLY_EXIT != 0) && w_first);

  // Only the most significant difference counts.
  assign w_gt_fin = r_have ? r_gt : w_cgt;
  assign w_lt_fin = r_have ? r_lt : w_clt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN:  if (w_finish) w_next = DONE;
      DONE: w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
    AeB  = r_res[RES_AEB];
    AsB  = r_res[RES_ASB];
    AiB  = r_res[RES_AIB];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_idx  <= '0;
      r_have <= 1'b0;
      r_gt   <= 1'b0;
      r_lt   <= 1'b0;
      r_res  <= '0;
    end else if (w_accept) begin
      r_sa   <= A;
      r_sb   <= B;
      r_idx  <= IDX_TOP;
      r_have <= 1'b0;
      r_gt   <= 1'b0;
      r_lt   <= 1'b0;
      r_res  <= '0;
    end else if (r_state == RUN) begin
      if (w_first) begin
        r_have <= 1'b1;
        r_gt   <= w_cgt;
        r_lt   <= w_clt;
      end
      if (w_finish)
        r_res <= res_pack(w_gt_fin, w_lt_fin);
      else
        r_idx <= r_idx - 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_serial_comparator_ctrl.sv
// Directed bench: early-exit and full-scan instances
// share clock, reset and operand inputs.
module tb_bit_serial_comparator_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;

  logic busy_e, done_e, aeb_e, asb_e, aib_e;
  logic busy_f, done_f, aeb_f, asb_f, aib_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_serial_comparator_ctrl #(
    .WIDTH(8), .EARLY_EXIT(1)
  ) u_ee (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B),
    .busy(busy_e), .done(done_e),
    .AeB(aeb_e), .AsB(asb_e), .AiB(aib_e)
  );

  bit_serial_comparator_ctrl #(
    .WIDTH(8), .EARLY_EXIT(0)
  ) u_full (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B),
    .busy(busy_f), .done(done_f),
    .AeB(aeb_f), .AsB(asb_f), .AiB(aib_f)
  );

  wire [2:0] res_e = {aeb_e, asb_e, aib_e};
  wire [2:0] res_f = {aeb_f, asb_f, aib_f};

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h",
        tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Edges are counted with the accepting edge as 1.
  task automatic run_cmp(
    input string      tag,
    input bit         full,
    input logic [7:0] a,
    input logic [7:0] b,
    input int         exp_edges,
    input logic [2:0] exp_res
  );
    int n;
    int bc;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n  = 1;
    bc = 0;
    while (!(full ? done_f : done_e) && n < 40) begin
      if (full ? busy_f : busy_e) bc++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_edges"}, n, exp_edges);
    chk({tag, "_busy"}, bc, exp_edges - 1);
    chk({tag, "_res"},
      full ? res_f : res_e, exp_res);
  endtask

  initial begin
    int pulses;
    bit bad;

    #12;
    chk("rst_busy", busy_e, 0);
    chk("rst_done", done_e, 0);
    chk("rst_res", res_e, 3'b000);
    chk("rst_res_f", res_f, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    run_cmp("t1", 0, 8'h80, 8'h7F, 2, 3'b010);
    idle(12);
    run_cmp("t2", 0, 8'h5A, 8'h5A, 9, 3'b100);
    idle(12);
    run_cmp("t3f", 1, 8'h12, 8'h13, 9, 3'b001);
    idle(12);
    run_cmp("t3e", 0, 8'h12, 8'h13, 9, 3'b001);
    idle(12);

    // start during busy ignored, start in DONE taken
    A = 8'hF0;
    B = 8'h0F;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_busy", busy_e, 1);
    A = 8'h00;
    B = 8'hFF;
    @(posedge clk);
    #1;
    chk("t4_done1", done_e, 1);
    chk("t4_res1", res_e, 3'b010);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t4_rerun", busy_e, 1);
    chk("t4_clr", res_e, 3'b000);
    @(posedge clk);
    #1;
    chk("t4_done2", done_e, 1);
    chk("t4_res2", res_e, 3'b001);
    idle(12);

    // reset three cycles into a compare
    A = 8'h01;
    B = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_busy", busy_e, 0);
    chk("t5_done", done_e, 0);
    chk("t5_res", res_e, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_e || done_f) pulses++;
    end
    chk("t5_nodone", pulses, 0);
    run_cmp("t5b", 0, 8'h01, 8'h01, 9, 3'b100);
    idle(12);

    // start held high: one compare per two cycles
    A = 8'hAA;
    B = 8'h55;
    start = 1'b1;
    pulses = 0;
    bad = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (aeb_e || aib_e) bad = 1'b1;
      chk("t6_done", done_e, (i % 2) == 0);
      if (done_e) begin
        pulses++;
        chk("t6_asb", asb_e, 1);
      end
    end
    start = 1'b0;
    chk("t6_pulses", pulses, 15);
    chk("t6_aeb_aib", bad, 0);
    idle(4);

    $display(
      "*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
